multi_ch_accum: RTL and testbench
=================================

# multi_ch_accum

Parametrised multi-channel accumulator, the successor of the single-channel 32-bit-in/100-bit-out accumulator circuit. Accumulates a stream of unsigned samples into one of N_CH independent wide accumulators, in plain-sum or sum-of-squares mode, with per-channel clear, sticky overflow flags and a registered readout port. Sits between a sample source driving `en`/`x` and any consumer reading totals by channel.

## Interface
- `DATA_W`, 32: input sample width, unsigned.
- `ACC_W`, 100: accumulator width. Must satisfy ACC_W >= 2*DATA_W.
- `N_CH`, 4: number of channels. Must be >= 2.
- `CH_W`, $clog2(N_CH): channel index width. Derived; do not override.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `en` in 1: sample valid. Sampled at every rising edge.
- `ch` in CH_W: target channel for `x`/`clr`. Values >= N_CH: operation dropped.
- `x` in DATA_W: sample.
- `sq` in 1: mode. 0 adds x, 1 adds x*x.
- `clr` in 1: clear channel `ch`. Valid with or without `en`.
- `rd_ch` in CH_W: readout channel select.
- `y` out ACC_W: registered value of accumulator `rd_ch`.
- `ovf` out N_CH: sticky per-channel overflow flags.

## Operation
- Two-stage pipeline.
  - Stage 1 registers `en`, `clr`, `ch`, and operand = sq ? x*x : {x zero-extended}. The operand is 2*DATA_W wide, zero-extended to ACC_W.
  - Stage 2 updates acc[ch_s1].
- Stage 2 update rules:
  - clr_s1 & en_s1: acc = operand; ovf[ch] = 0.
  - clr_s1 & !en_s1: acc = 0; ovf[ch] = 0.
  - !clr_s1 & en_s1: acc = acc + operand, ACC_W+1-bit sum. A carry out sets ovf[ch].
  - Otherwise: hold.
- Only stage 2 writes the accumulators, so back-to-back samples to the same channel need no forwarding. Every sample is counted exactly once.
- Without saturation, the sum wraps modulo 2^ACC_W.
- `y` <= acc[rd_ch] every cycle, independent of `en`.
- Out-of-range `ch` (N_CH not a power of 2): no accumulator or flag changes.
- Reset (`rst`=0, any time, including with samples in flight):
  - All accumulators, pipeline registers, `y` and `ovf` go to 0 immediately.
  - In-flight samples are discarded.
  - The first sample accepted after `rst` rises counts normally.

## Timing
- Sample presented with `en`=1 before edge k:
  - Operand registered at k.
  - acc updated at k+1.
  - Visible on `y` (if `rd_ch` matches) after edge k+2.
- `ovf` changes at k+1, together with the accumulator.
- `rd_ch` change at edge j: `y` shows the new channel after edge j+1. Readout latency is 1 cycle.
- Throughput: one sample per cycle, no stall, no ready signal.
- Clear has the same 2-cycle latency as a sample, so clear/sample ordering on a channel is preserved.
- Accumulator update and readout of the same channel at the same edge: `y` shows the pre-update value that cycle and the updated value the next.

## Configuration
- `ACC_SAT_EN` defined:
  - When the ACC_W+1-bit sum has its carry set, acc saturates to 2^ACC_W-1.
  - ovf[ch] is still set.
  - A saturated accumulator stays at max on further adds until cleared.
- `ACC_SAT_EN` undefined: modulo-2^ACC_W wrap; ovf[ch] set on carry.
- Both builds: same latency and port list.

## Test plan
- Default params, sq=0, ch=0, x=0..99 on consecutive cycles, rd_ch=0 -> `y`=4950 two cycles after the last sample; ovf=0.
- Default params, sq=1, ch=1, x=0..99 -> `y`=328350 with rd_ch=1; channel 0 still reads 0.
- Interleaved ch=2 (x=10) and ch=3 (x=7), 20 samples each, alternating every cycle -> ch2=200, ch3=140.
- clr=1 with en=1, x=5 on a channel holding 1000 -> channel reads 5; clr alone -> 0 and ovf bit cleared.
- DATA_W=8, ACC_W=16, sq=1, x=255 twice on ch 0:
  - without ACC_SAT_EN -> `y`=64514, ovf[0]=1;
  - with ACC_SAT_EN -> `y`=65535, ovf[0]=1.
- Assert `rst` low for 3 cycles mid-stream, with a sample in each pipeline stage -> `y`=0, ovf=0 during reset; post-reset stream of x=1..4 -> 10.

Source files
------------

// File: rtl/multi_ch_accum.sv
// multi_ch_accum: N_CH independent wide accumulators fed by one unsigned
// sample stream, in plain-sum or sum-of-squares mode. Each channel has a
// clear and a sticky overflow flag. The total of channel rd_ch is returned
// on a registered readout port.
//
// Two-stage pipeline:
//   stage 1: registers en/clr/ch and the operand (x or x*x, 2*DATA_W wide).
//   stage 2: the only writer of the accumulators and overflow flags.
// Because all accumulator writes happen in one stage, consecutive samples
// to the same channel read the value stage 2 has just written, so no
// forwarding path is needed.
//
// Build option: define ACC_SAT_EN to saturate a channel at 2^ACC_W-1 when
// an add carries out. When it is undefined the sum wraps modulo 2^ACC_W.
// In both builds a carry out sets the channel's ovf bit.
module multi_ch_accum #(
  parameter  int DATA_W = 32,
  parameter  int ACC_W  = 100,
  parameter  int N_CH   = 4,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,     // asynchronous, active-low
  input  logic              en,
  input  logic [CH_W-1:0]   ch,
  input  logic [DATA_W-1:0] x,
  input  logic              sq,
  input  logic              clr,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [ACC_W-1:0]  y,
  output logic [N_CH-1:0]   ovf
);

  localparam int OP_W = 2 * DATA_W;

  // Reject parameter sets that cannot hold a full-width square.
  if (ACC_W < OP_W) begin : g_bad_acc_w
    $error("multi_ch_accum: ACC_W must be >= 2*DATA_W");
  end
  if (N_CH < 2) begin : g_bad_n_ch
    $error("multi_ch_accum: N_CH must be >= 2");
  end

  // ---------------------------------------------------------------------
  // Stage 1: operand formation
  // ---------------------------------------------------------------------
  logic [OP_W-1:0] op_d;

  logic            en_s1;
  logic            clr_s1;
  logic [CH_W-1:0] ch_s1;
  logic [OP_W-1:0] op_s1;

  // Square or zero-extend the incoming sample to the operand width.
  // NOTE: every always_comb output gets a value on every path (here via the
  // ternary, below via a default first) so no latch is inferred.
  always_comb begin
    op_d = sq ? (OP_W'(x) * OP_W'(x)) : OP_W'(x);
  end

  // Register the request and its operand; reset drops any sample in flight.
  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples its inputs as they were before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_s1  <= 1'b0;
      clr_s1 <= 1'b0;
      ch_s1  <= '0;
      op_s1  <= '0;
    end else begin
      en_s1  <= en;
      clr_s1 <= clr;
      ch_s1  <= ch;
      op_s1  <= op_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: accumulator update
  // ---------------------------------------------------------------------
  logic [ACC_W-1:0] acc [N_CH];
  logic [ACC_W-1:0] acc_cur;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic [ACC_W-1:0] rd_val;

  // Select the addressed accumulator; an out-of-range channel matches
  // nothing and reads as zero (its result is never written anyway).
  always_comb begin
    acc_cur = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_s1 == CH_W'(i)) acc_cur = acc[i];
    end
  end

  // One extra bit on the adder exposes the carry used for overflow.
  always_comb begin
    sum   = (ACC_W + 1)'(acc_cur) + (ACC_W + 1)'(op_s1);
    carry = sum[ACC_W];
`ifdef ACC_SAT_EN
    acc_add = carry ? '1 : sum[ACC_W-1:0];
`else
    acc_add = sum[ACC_W-1:0];
`endif
  end

  // Apply clear / load / add / hold to the addressed channel only.
  // NOTE: the accumulator array is reset asynchronously along with the
  // flags because a reset must return every channel total to zero at once;
  // this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) acc[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_s1 == CH_W'(i)) begin
          if (clr_s1) begin
            // Clear, optionally loading this cycle's sample as the new total.
            acc[i] <= en_s1 ? ACC_W'(op_s1) : '0;
            ovf[i] <= 1'b0;
          end else if (en_s1) begin
            acc[i] <= acc_add;
            if (carry) ovf[i] <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Readout
  // ---------------------------------------------------------------------

  // Pick the channel to read; out-of-range selects read as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CH_W'(i)) rd_val = acc[i];
    end
  end

  // Register the readout; same-edge updates show up one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) y <= '0;
    else      y <= rd_val;
  end

endmodule

// File: tb/tb_multi_ch_accum.sv
// Self-checking bench for multi_ch_accum. Two instances share one stimulus
// stream: a default build (32-bit samples, 100-bit totals, 4 channels) and a
// narrow one (8-bit samples, 16-bit totals, 3 channels) that overflows
// readily and has an unused channel code. A reference model applies each
// request to plain integer totals; the expected readout for every clock
// edge goes into a queue that a separate monitor drains and compares.
module tb_multi_ch_accum;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  ch;
  logic [31:0] x;
  logic        sq;
  logic        clr;
  logic [1:0]  rd_ch;

  logic [99:0] y_a;
  logic [3:0]  ovf_a;
  logic [15:0] y_b;
  logic [2:0]  ovf_b;

  multi_ch_accum #(.DATA_W(32), .ACC_W(100), .N_CH(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .ch(ch), .x(x), .sq(sq), .clr(clr),
    .rd_ch(rd_ch), .y(y_a), .ovf(ovf_a)
  );

  multi_ch_accum #(.DATA_W(8), .ACC_W(16), .N_CH(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .ch(ch), .x(x[7:0]), .sq(sq), .clr(clr),
    .rd_ch(rd_ch), .y(y_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance configuration used by the model.
  localparam int ACCW [2] = '{100, 16};
  localparam int DW   [2] = '{32, 8};
  localparam int NCH  [2] = '{4, 3};

  typedef struct {
    logic [127:0] y;
    logic [3:0]   ovf;
  } exp_t;

  typedef struct {
    bit          e;
    bit          c;
    int          chv;
    logic [31:0] xv;
    bit          s;
  } op_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [128:0] mdl [2][4];
  logic [3:0]   mov [2];
  op_t          pend;
  bit           pend_v;

  int  rd_sel;
  bit  rst_v;
  int  n_checks;
  int  n_errors;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) mdl[k][i] = '0;
      mov[k] = '0;
    end
    pend_v = 1'b0;
  endfunction

  // Reference behaviour of one request on instance k, in plain arithmetic.
  function automatic void apply(input int k, input op_t o);
    logic [128:0] lim, xm, opv, s;
    if (!o.e && !o.c) return;
    if (o.chv >= NCH[k]) return;
    lim = 129'd1 << ACCW[k];
    xm  = {97'd0, o.xv} & ((129'd1 << DW[k]) - 129'd1);
    opv = o.s ? xm * xm : xm;
    if (o.c) begin
      mdl[k][o.chv] = o.e ? opv : '0;
      mov[k][o.chv] = 1'b0;
    end else begin
      s = mdl[k][o.chv] + opv;
      if (s >= lim) begin
        mov[k][o.chv] = 1'b1;
`ifdef ACC_SAT_EN
        mdl[k][o.chv] = lim - 129'd1;
`else
        mdl[k][o.chv] = s - lim;
`endif
      end else begin
        mdl[k][o.chv] = s;
      end
    end
  endfunction

  // Drive one clock's worth of inputs and queue the outputs expected just
  // after that clock edge. The readout at an edge shows totals that include
  // requests up to two edges earlier; the flags include the previous edge.
  task automatic cyc(input bit e, input bit c, input int chv,
                     input logic [31:0] xv, input bit s);
    exp_t ea, eb;
    op_t  cur;
    @(negedge clk);
    #1;
    rst   = rst_v;
    en    = e;
    clr   = c;
    ch    = 2'(chv);
    x     = xv;
    sq    = s;
    rd_ch = 2'(rd_sel);
    cur   = '{e: e, c: c, chv: chv, xv: xv, s: s};
    if (!rst_v) begin
      model_reset();
      ea = '{y: '0, ovf: '0};
      eb = '{y: '0, ovf: '0};
    end else begin
      ea.y = mdl[0][rd_sel][127:0];
      eb.y = (rd_sel < NCH[1]) ? mdl[1][rd_sel][127:0] : '0;
      if (pend_v) begin
        apply(0, pend);
        apply(1, pend);
      end
      ea.ovf = mov[0];
      eb.ovf = mov[1];
      pend   = cur;
      pend_v = 1'b1;
    end
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'd0, 0);
  endtask

  // Monitor: the readout is valid every cycle; compare away from the edge.
  initial begin
    exp_t ea, eb;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        ea = q_a.pop_front();
        check("y_a", 128'(y_a), ea.y);
        check("ovf_a", 128'(ovf_a), 128'(ea.ovf));
      end
      if (q_b.size() > 0) begin
        eb = q_b.pop_front();
        check("y_b", 128'(y_b), eb.y);
        check("ovf_b", 128'({1'b0, ovf_b}), 128'(eb.ovf));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] sat_exp;
    n_checks = 0;
    n_errors = 0;
    rst_v  = 1'b0;
    rst    = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;
    ch     = '0;
    x      = '0;
    sq     = 1'b0;
    rd_ch  = '0;
    rd_sel = 0;
    model_reset();

    // Reset for a few cycles, then release.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 32'd0, 0);
    check("reset_y_a", 128'(y_a), 128'd0);
    check("reset_ovf_a", 128'(ovf_a), 128'd0);
    rst_v = 1'b1;
    cyc(0, 0, 0, 32'd0, 0);

    // Plain sum 0..99 on channel 0.
    rd_sel = 0;
    for (int i = 0; i < 100; i++) cyc(1, 0, 0, 32'(i), 0);
    settle();
    check("sum_0_99", 128'(y_a), 128'd4950);
    check("sum_ovf", 128'(ovf_a), 128'd0);

    // Sum of squares 0..99 on channel 1.
    rd_sel = 1;
    for (int i = 0; i < 100; i++) cyc(1, 0, 1, 32'(i), 1);
    settle();
    check("sq_sum_0_99", 128'(y_a), 128'd328350);
    check("sq_ovf_b1", 128'(ovf_b[1]), 128'd1);

    // Interleaved channels 2 and 3 (channel 3 does not exist on dut_b).
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) cyc(1, 0, 2, 32'd10, 0);
      else            cyc(1, 0, 3, 32'd7, 0);
    end
    rd_sel = 2;
    settle();
    check("ilv_ch2", 128'(y_a), 128'd200);
    rd_sel = 3;
    settle();
    check("ilv_ch3", 128'(y_a), 128'd140);
    check("ilv_ch3_b", 128'(y_b), 128'd0);

    // Clear-with-load, then clear alone.
    rd_sel = 0;
    cyc(1, 1, 0, 32'd1000, 0);
    settle();
    check("clr_load_1000", 128'(y_a), 128'd1000);
    cyc(1, 1, 0, 32'd5, 0);
    settle();
    check("clr_load_5", 128'(y_a), 128'd5);
    check("clr_load_5_b", 128'(y_b), 128'd5);
    cyc(0, 1, 1, 32'd0, 0);
    cyc(0, 1, 0, 32'd0, 0);
    settle();
    check("clr_only", 128'(y_a), 128'd0);
    check("clr_ovf_b1", 128'(ovf_b[1]), 128'd0);

    // Two 255^2 samples: narrow build overflows.
    cyc(1, 0, 0, 32'd255, 1);
    cyc(1, 0, 0, 32'd255, 1);
    settle();
`ifdef ACC_SAT_EN
    sat_exp = 128'd65535;
`else
    sat_exp = 128'd64514;
`endif
    check("ovf_y_b", 128'(y_b), sat_exp);
    check("ovf_flag_b0", 128'(ovf_b[0]), 128'd1);
    check("ovf_y_a", 128'(y_a), 128'd130050);
    check("ovf_flag_a0", 128'(ovf_a[0]), 128'd0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rd_sel = int'($urandom_range(0, 3));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          int'($urandom_range(0, 3)), $urandom, $urandom_range(0, 1) == 1);
    end

    // Reset mid-stream with samples in flight.
    rd_sel = 0;
    cyc(1, 0, 0, 32'd50, 0);
    cyc(1, 0, 0, 32'd60, 0);
    rst_v = 1'b0;
    cyc(1, 0, 0, 32'd70, 0);
    cyc(1, 0, 1, 32'd80, 1);
    cyc(0, 0, 0, 32'd0, 0);
    check("rst_mid_y_a", 128'(y_a), 128'd0);
    check("rst_mid_ovf_a", 128'(ovf_a), 128'd0);
    check("rst_mid_ovf_b", 128'(ovf_b), 128'd0);
    rst_v = 1'b1;
    for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 32'(i), 0);
    settle();
    check("post_rst_a", 128'(y_a), 128'd10);
    check("post_rst_b", 128'(y_b), 128'd10);

    // Let the monitor take the last queued entry.
    @(negedge clk);
    #2;
    check("drain_a", 128'(q_a.size()), 128'd0);
    check("drain_b", 128'(q_b.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
